// File: rtl/ghash_pkg.sv
// Shared types and the reflected GF(2^128) multiply-by-x step used by the GHASH multiplier.
package ghash_pkg;

  localparam logic [127:0] GF128_R = 128'hE1000000000000000000000000000000;

  typedef logic [127:0] gf128_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } ghash_state_e;

  // Bit 127 holds x^0, so multiplying by x is a right shift with reduction on carry-out.
  function automatic gf128_t gf128_mulx(input gf128_t v);
    gf128_mulx = v[0] ? ((v >> 1) ^ GF128_R) : (v >> 1);
  endfunction

endpackage

// File: rtl/ghash_digit_step.sv
// One digit of the shift-and-add GF(2^128) multiply: consumes DIGIT_BITS operand bits, MSB first.
module ghash_digit_step
  import ghash_pkg::*;
#(
  parameter int DIGIT_BITS = 8
) (
  input  gf128_t                z_cur,
  input  gf128_t                v_cur,
  input  logic [DIGIT_BITS-1:0] digit,
  output gf128_t                z_next,
  output gf128_t                v_next
);

  always_comb begin
    z_next = z_cur;
    v_next = v_cur;
    for (int j = DIGIT_BITS - 1; j >= 0; j--) begin
      if (digit[j]) z_next = z_next ^ v_next;
      v_next = gf128_mulx(v_next);
    end
  end

endmodule

// File: rtl/ghash_mult_serial.sv
// Digit-serial GHASH multiplier with H register and chained accumulator Y = (Y ^ A) * H.
//
// state | meaning
// IDLE  | ready for an operand; latches P, Z = 0, V = H_eff on accept
// BUSY  | one digit of P per cycle for N cycles; H writes ignored
// DONE  | result held on x_o until out_ready
module ghash_mult_serial
  import ghash_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DIGIT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  h_we,
  input  logic [DATA_WIDTH-1:0] h_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic                  acc_en_i,
  input  logic                  acc_clr_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] x_o,
  output logic [DATA_WIDTH-1:0] acc_o
);

  localparam int N = DATA_WIDTH / DIGIT_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  ghash_state_e state, state_next;

  logic [CNT_W-1:0] cnt;
  gf128_t z_q, v_q, p_q, h_q, x_q, acc_q;
  gf128_t z_step, v_step;
  logic   last_digit;

  assign last_digit = (cnt == CNT_LAST);

  ghash_digit_step #(
    .DIGIT_BITS(DIGIT_BITS)
  ) u_step (
    .z_cur (z_q),
    .v_cur (v_q),
    .digit (p_q[DATA_WIDTH-1 -: DIGIT_BITS]),
    .z_next(z_step),
    .v_next(v_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      z_q   <= '0;
      v_q   <= '0;
      p_q   <= '0;
      h_q   <= '0;
      x_q   <= '0;
      acc_q <= '0;
    end else begin
      if (h_we && state != BUSY) h_q <= h_i;

      // Clear beats the end-of-product write; the accept below still sees the old value.
      if (acc_clr_i)                    acc_q <= '0;
      else if (state == BUSY && last_digit) acc_q <= z_step;

      case (state)
        IDLE: begin
          if (in_valid) begin
            p_q <= a_i ^ (acc_en_i ? acc_q : '0);
            z_q <= '0;
            v_q <= h_we ? h_i : h_q;
            cnt <= '0;
          end
        end
        BUSY: begin
          z_q <= z_step;
          v_q <= v_step;
          p_q <= p_q << DIGIT_BITS;
          cnt <= cnt + CNT_W'(1);
          if (last_digit) x_q <= z_step;
        end
        default: ;
      endcase
    end
  end

  assign x_o   = x_q;
  assign acc_o = acc_q;

endmodule
